// File: rtl/csr_counters.sv
// csr_counters: machine cycle/instret counters with a small CSR read/write port.
//
// Ports:
//   clk_i           sole clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   retire_w_i      one instruction retired this cycle
//   csr_addr_i      12-bit CSR address (read and write)
//   csr_rd_en_i     read request; data returned one cycle later
//   csr_wr_en_i     write request; applied on the same edge
//   csr_wdata_i     write data
//   csr_rdata_o     registered read data, holds when no read
//   csr_rd_valid_o  csr_rdata_o valid this cycle
//   csr_illegal_o   previous-cycle access was illegal
module csr_counters #(
   parameter logic [2:0]  INHIBIT_RST = 3'b000,
   parameter int unsigned HPM_EN      = 0
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        retire_w_i,
   input  logic [11:0] csr_addr_i,
   input  logic        csr_rd_en_i,
   input  logic        csr_wr_en_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_rd_valid_o,
   output logic        csr_illegal_o
);

   logic [63:0] r_mcycle, r_minstret;
   logic [2:0]  r_inhibit;
   logic [31:0] r_rdata;
   logic        r_rd_valid, r_illegal;

   logic        w_cyc_lo, w_cyc_hi, w_ins_lo, w_ins_hi, w_inh, w_hpm;
   logic        w_mapped, w_ro, w_wr_ok;
   logic [31:0] w_rd_val;
   logic [63:0] w_mcycle_inc, w_minstret_inc, w_mcycle_d, w_minstret_d;
   logic [2:0]  w_inhibit_d;

   // Address decode; 0xCxx aliases read the matching 0xBxx counter.
   always_comb begin
      w_cyc_lo = (csr_addr_i == 12'hB00) || (csr_addr_i == 12'hC00);
      w_cyc_hi = (csr_addr_i == 12'hB80) || (csr_addr_i == 12'hC80);
      w_ins_lo = (csr_addr_i == 12'hB02) || (csr_addr_i == 12'hC02);
      w_ins_hi = (csr_addr_i == 12'hB82) || (csr_addr_i == 12'hC82);
      w_inh    = (csr_addr_i == 12'h320);
      // hpmcounter3..31 (lo and hi, machine and user views) read as zero
      // while no hardware performance counters are built.
      w_hpm    = ((csr_addr_i[11:8] == 4'hB) || (csr_addr_i[11:8] == 4'hC)) &&
                 (csr_addr_i[6:5] == 2'b00) && (csr_addr_i[4:0] >= 5'd3) &&
                 (HPM_EN == 0);
      w_mapped = w_cyc_lo | w_cyc_hi | w_ins_lo | w_ins_hi | w_inh | w_hpm;
      w_ro     = (csr_addr_i[11:8] == 4'hC);
      w_wr_ok  = csr_wr_en_i && w_mapped && !w_ro;
   end

   always_comb begin
      w_rd_val = 32'h0;
      if (w_cyc_lo)      w_rd_val = r_mcycle[31:0];
      else if (w_cyc_hi) w_rd_val = r_mcycle[63:32];
      else if (w_ins_lo) w_rd_val = r_minstret[31:0];
      else if (w_ins_hi) w_rd_val = r_minstret[63:32];
      else if (w_inh)    w_rd_val = {29'h0, r_inhibit};
   end

   // Counter next-state. A written half takes the write data verbatim; when the
   // lo half is written, the increment's carry into hi is dropped.
   always_comb begin
      w_mcycle_inc   = r_mcycle + {63'h0, ~r_inhibit[0]};
      w_minstret_inc = r_minstret + {63'h0, retire_w_i & ~r_inhibit[2]};

      w_mcycle_d = w_mcycle_inc;
      if (w_wr_ok && w_cyc_lo) begin
         w_mcycle_d[31:0]  = csr_wdata_i;
         w_mcycle_d[63:32] = r_mcycle[63:32];
      end
      if (w_wr_ok && w_cyc_hi) w_mcycle_d[63:32] = csr_wdata_i;

      w_minstret_d = w_minstret_inc;
      if (w_wr_ok && w_ins_lo) begin
         w_minstret_d[31:0]  = csr_wdata_i;
         w_minstret_d[63:32] = r_minstret[63:32];
      end
      if (w_wr_ok && w_ins_hi) w_minstret_d[63:32] = csr_wdata_i;

      w_inhibit_d = r_inhibit;
      // TM (bit 1) is hardwired to zero.
      if (w_wr_ok && w_inh) w_inhibit_d = {csr_wdata_i[2], 1'b0, csr_wdata_i[0]};
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_mcycle   <= 64'h0;
         r_minstret <= 64'h0;
         r_inhibit  <= INHIBIT_RST & 3'b101;
         r_rdata    <= 32'h0;
         r_rd_valid <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_mcycle   <= w_mcycle_d;
         r_minstret <= w_minstret_d;
         r_inhibit  <= w_inhibit_d;
         r_rd_valid <= csr_rd_en_i;
         r_illegal  <= (csr_rd_en_i && !w_mapped) ||
                       (csr_wr_en_i && (!w_mapped || w_ro));
         if (csr_rd_en_i) r_rdata <= w_mapped ? w_rd_val : 32'h0;
      end
   end

   assign csr_rdata_o    = r_rdata;
   assign csr_rd_valid_o = r_rd_valid;
   assign csr_illegal_o  = r_illegal;

endmodule
